// File: rtl/chess_pkg.sv
// Shared state encoding and player identifiers for the chess clock sequencer.
package chess_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN_P1  = 3'd1,
        ST_RUN_P2  = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    function automatic logic is_running(input state_t s);
        return (s == ST_RUN_P1) || (s == ST_RUN_P2);
    endfunction

    function automatic state_t run_state(input logic player);
        return (player == PLAYER_2) ? ST_RUN_P2 : ST_RUN_P1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Second-impulse divider: counts running cycles 0..TICK_DIV-1 and emits a registered
// one-cycle TICK during the running cycle whose count is TICK_DIV-1.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic CLR,
    input  logic EN,
    input  logic SYNC_CLR,
    output logic TICK
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          run_q;

    // EN describes the coming cycle; run_q says whether the cycle now ending was a running one.
    always_comb begin
        cnt_d = cnt_q;
        if (SYNC_CLR) begin
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt_q <= '0;
            run_q <= 1'b0;
            TICK  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= EN;
            TICK  <= EN && (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Chess clock game sequencer: turn FSM, chain clock enables, flag-fall latch and reload pulse.
// Optional per-move delay is compiled in with the CHESS_DELAY_EN macro.
module chess_turn_ctrl
    import chess_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DELAY_S  = 5
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       BTN_START,
    input  logic       BTN_NEW,
    input  logic       BTN_P1,
    input  logic       BTN_P2,
    input  logic       OVF_P1,
    input  logic       OVF_P2,
    output logic       CE_P1,
    output logic       CE_P2,
    output logic       IMPULSE,
    output logic       RELOAD,
    output logic       ACTIVE,
    output logic       RUNNING,
    output logic [1:0] FLAG,
    output state_t     STATE
);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("TICK_DIV must be at least 2");
    end
    if ((DELAY_S < 0) || (DELAY_S > 15)) begin : g_bad_delay
        $error("DELAY_S must be within 0..15");
    end

    state_t     state_q, state_d;
    logic       active_q, active_d;
    logic [1:0] flag_q, flag_d;
    logic [1:0] ce_q, ce_d;
    logic       reload_q, reload_d;
    logic       switch_turn;
    logic       presc_clr;
    logic       run_d;
    logic       gate_open;

    // Priority: BTN_NEW, then flag-fall, then start/pause, then the move button.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        flag_d      = flag_q;
        reload_d    = 1'b0;
        switch_turn = 1'b0;
        if (BTN_NEW) begin
            state_d  = ST_IDLE;
            active_d = PLAYER_1;
            flag_d   = 2'b00;
            reload_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (BTN_START) state_d = ST_RUN_P1;
                end
                ST_RUN_P1: begin
                    if (ce_q[0] && OVF_P1) begin
                        state_d   = ST_TIMEOUT;
                        flag_d[0] = 1'b1;
                    end else if (BTN_START) begin
                        state_d = ST_PAUSED;
                    end else if (BTN_P1) begin
                        state_d     = ST_RUN_P2;
                        active_d    = PLAYER_2;
                        switch_turn = 1'b1;
                    end
                end
                ST_RUN_P2: begin
                    if (ce_q[1] && OVF_P2) begin
                        state_d   = ST_TIMEOUT;
                        flag_d[1] = 1'b1;
                    end else if (BTN_START) begin
                        state_d = ST_PAUSED;
                    end else if (BTN_P2) begin
                        state_d     = ST_RUN_P1;
                        active_d    = PLAYER_1;
                        switch_turn = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (BTN_START) state_d = run_state(active_q);
                end
                ST_TIMEOUT: begin
                    state_d = ST_TIMEOUT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign presc_clr = BTN_NEW || switch_turn;
    assign run_d     = is_running(state_d);

`ifdef CHESS_DELAY_EN
    localparam logic [3:0] DELAY_INIT = 4'(DELAY_S);

    logic [3:0] delay_q, delay_d;

    // Delay only counts impulses, and impulses only occur while running, so PAUSED freezes it.
    always_comb begin
        delay_d = delay_q;
        if (BTN_NEW) begin
            delay_d = 4'd0;
        end else if (switch_turn) begin
            delay_d = DELAY_INIT;
        end else if (IMPULSE && (delay_q != 4'd0)) begin
            delay_d = delay_q - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) delay_q <= 4'd0;
        else     delay_q <= delay_d;
    end

    assign gate_open = (delay_d == 4'd0);
`else
    assign gate_open = 1'b1;
`endif

    assign ce_d[0] = (state_d == ST_RUN_P1) && gate_open;
    assign ce_d[1] = (state_d == ST_RUN_P2) && gate_open;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= ST_IDLE;
            active_q <= PLAYER_1;
            flag_q   <= 2'b00;
            ce_q     <= 2'b00;
            reload_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            flag_q   <= flag_d;
            ce_q     <= ce_d;
            reload_q <= reload_d;
        end
    end

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .CLK     (CLK),
        .CLR     (CLR),
        .EN      (run_d),
        .SYNC_CLR(presc_clr),
        .TICK    (IMPULSE)
    );

    assign CE_P1   = ce_q[0];
    assign CE_P2   = ce_q[1];
    assign RELOAD  = reload_q;
    assign ACTIVE  = active_q;
    assign RUNNING = is_running(state_q);
    assign FLAG    = flag_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Bench for chess_turn_ctrl (TICK_DIV=4, DELAY_S=2): directed vector table, delay sequence,
// then randomized stimulus against a behavioural game model.
module tb_chess_turn_ctrl;
    import chess_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int DELAY_S  = 2;
`ifdef CHESS_DELAY_EN
    localparam int DLY = DELAY_S;
`else
    localparam int DLY = 0;
`endif
    localparam logic NODLY = (DLY == 0);

    typedef struct {
        logic clr, start, newg, p1, p2, ovf1, ovf2;
    } stim_t;

    typedef struct {
        stim_t      in;
        logic       ce1, ce2, imp, act, run, reload;
        logic [1:0] flag;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic btn_start = 1'b0, btn_new = 1'b0, btn_p1 = 1'b0, btn_p2 = 1'b0;
    logic ovf_p1 = 1'b0, ovf_p2 = 1'b0;
    logic ce_p1, ce_p2, impulse, reload, active, running;
    logic [1:0] flag;
    state_t state;

    always #5 clk = ~clk;

    chess_turn_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DELAY_S (DELAY_S)
    ) dut (
        .CLK(clk), .CLR(clr), .BTN_START(btn_start), .BTN_NEW(btn_new),
        .BTN_P1(btn_p1), .BTN_P2(btn_p2), .OVF_P1(ovf_p1), .OVF_P2(ovf_p2),
        .CE_P1(ce_p1), .CE_P2(ce_p2), .IMPULSE(impulse), .RELOAD(reload),
        .ACTIVE(active), .RUNNING(running), .FLAG(flag), .STATE(state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Game model: a game in progress, clock running or not, whose turn, cycles into the current second.
    bit         m_started, m_running, m_over, m_turn, m_reload, m_impulse;
    int         m_phase, m_wait;
    logic [1:0] m_flag, m_ce;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_started = 0; m_running = 0; m_over = 0; m_turn = 0;
        m_phase = 0; m_wait = 0; m_flag = 2'b00;
    endtask

    task automatic model_step(input stim_t s);
        logic [1:0] ce_before;
        bit imp_before;
        bit ovf_hit, move_hit;
        ce_before  = m_ce;
        imp_before = m_impulse;
        m_reload   = 0;
        if (s.clr || s.newg) begin
            model_clear();
            m_reload = 1;
        end else begin
            if (m_running) m_phase = (m_phase + 1) % TICK_DIV;
            if (imp_before && m_wait > 0) m_wait--;
            if (m_running) begin
                ovf_hit  = m_turn ? (s.ovf2 && ce_before[1]) : (s.ovf1 && ce_before[0]);
                move_hit = m_turn ? s.p2 : s.p1;
                if (ovf_hit) begin
                    m_over = 1; m_running = 0; m_flag[m_turn] = 1'b1;
                end else if (s.start) begin
                    m_running = 0;
                end else if (move_hit) begin
                    m_turn = !m_turn; m_phase = 0; m_wait = DLY;
                end
            end else if (!m_over && s.start) begin
                m_running = 1; m_started = 1;
            end
        end
        m_impulse = m_running && (m_phase == TICK_DIV - 1);
        m_ce = 2'b00;
        if (m_running && m_wait == 0) m_ce[m_turn] = 1'b1;
    endtask

    function automatic state_t model_state();
        if (m_over) return ST_TIMEOUT;
        if (m_running) return m_turn ? ST_RUN_P2 : ST_RUN_P1;
        return m_started ? ST_PAUSED : ST_IDLE;
    endfunction

    task automatic compare_model();
        check("model_ce_p1", ce_p1, m_ce[0]);
        check("model_ce_p2", ce_p2, m_ce[1]);
        check("model_impulse", impulse, m_impulse);
        check("model_reload", reload, m_reload);
        check("model_active", active, m_turn);
        check("model_running", running, m_running);
        check("model_flag", flag, m_flag);
        check("model_state", state, model_state());
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        clr = s.clr; btn_start = s.start; btn_new = s.newg;
        btn_p1 = s.p1; btn_p2 = s.p2; ovf_p1 = s.ovf1; ovf_p2 = s.ovf2;
        @(posedge clk);
        model_step(s);
        #1;
        compare_model();
    endtask

    function automatic stim_t st(input logic c, input logic s, input logic n, input logic a,
                                 input logic b, input logic o1, input logic o2);
        stim_t r;
        r.clr = c; r.start = s; r.newg = n; r.p1 = a; r.p2 = b; r.ovf1 = o1; r.ovf2 = o2;
        return r;
    endfunction

    function automatic vec_t mk(input stim_t s, input logic ce1, input logic ce2, input logic imp,
                                input logic act, input logic run, input logic [1:0] fl,
                                input logic rl);
        vec_t v;
        v.in = s; v.ce1 = ce1; v.ce2 = ce2; v.imp = imp; v.act = act; v.run = run;
        v.flag = fl; v.reload = rl;
        return v;
    endfunction

    vec_t  vec[$];
    stim_t idle_s, rs;
    int    imp_cnt, first_imp, last_imp, dly_imps;
    bit    seen;

    initial begin
        idle_s = st(0, 0, 0, 0, 0, 0, 0);
        //                clr st nw p1 p2 o1 o2      ce1 ce2    imp act run flag   rel
        vec.push_back(mk(st(1, 0, 0, 0, 0, 0, 0),   0, 0,     0, 0, 0, 2'b00, 1));
        vec.push_back(mk(idle_s,                    0, 0,     0, 0, 0, 2'b00, 0));
        vec.push_back(mk(st(0, 1, 0, 0, 0, 0, 0),   1, 0,     0, 0, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    1, 0,     0, 0, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    1, 0,     0, 0, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    1, 0,     1, 0, 1, 2'b00, 0));
        vec.push_back(mk(st(0, 0, 0, 0, 1, 0, 0),   1, 0,     0, 0, 1, 2'b00, 0));
        vec.push_back(mk(st(0, 0, 0, 0, 0, 0, 1),   1, 0,     0, 0, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    1, 0,     0, 0, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    1, 0,     1, 0, 1, 2'b00, 0));
        vec.push_back(mk(st(0, 0, 0, 1, 0, 0, 0),   0, NODLY, 0, 1, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, NODLY, 0, 1, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, NODLY, 0, 1, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, NODLY, 1, 1, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, NODLY, 0, 1, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, NODLY, 0, 1, 1, 2'b00, 0));
        vec.push_back(mk(st(0, 1, 0, 0, 1, 0, 0),   0, 0,     0, 1, 0, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, 0,     0, 1, 0, 2'b00, 0));
        vec.push_back(mk(st(0, 0, 0, 1, 0, 0, 0),   0, 0,     0, 1, 0, 2'b00, 0));
        vec.push_back(mk(st(0, 1, 0, 0, 0, 0, 0),   0, NODLY, 0, 1, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, NODLY, 1, 1, 1, 2'b00, 0));
        vec.push_back(mk(idle_s,                    0, 1,     0, 1, 1, 2'b00, 0));
        vec.push_back(mk(st(0, 0, 0, 0, 1, 0, 1),   0, 0,     0, 1, 0, 2'b10, 0));
        vec.push_back(mk(st(0, 1, 0, 0, 0, 0, 0),   0, 0,     0, 1, 0, 2'b10, 0));
        vec.push_back(mk(st(0, 0, 0, 1, 0, 1, 0),   0, 0,     0, 1, 0, 2'b10, 0));
        vec.push_back(mk(st(0, 0, 1, 0, 0, 0, 0),   0, 0,     0, 0, 0, 2'b00, 1));
        vec.push_back(mk(idle_s,                    0, 0,     0, 0, 0, 2'b00, 0));
        vec.push_back(mk(st(0, 1, 0, 0, 0, 0, 0),   1, 0,     0, 0, 1, 2'b00, 0));
        vec.push_back(mk(st(0, 1, 0, 0, 0, 1, 0),   0, 0,     0, 0, 0, 2'b01, 0));
        vec.push_back(mk(st(0, 1, 1, 0, 0, 0, 0),   0, 0,     0, 0, 0, 2'b00, 1));
        vec.push_back(mk(idle_s,                    0, 0,     0, 0, 0, 2'b00, 0));

        for (int i = 0; i < vec.size(); i++) begin
            drive(vec[i].in);
            check($sformatf("vec%0d_ce_p1", i), ce_p1, vec[i].ce1);
            check($sformatf("vec%0d_ce_p2", i), ce_p2, vec[i].ce2);
            check($sformatf("vec%0d_impulse", i), impulse, vec[i].imp);
            check($sformatf("vec%0d_active", i), active, vec[i].act);
            check($sformatf("vec%0d_running", i), running, vec[i].run);
            check($sformatf("vec%0d_flag", i), flag, vec[i].flag);
            check($sformatf("vec%0d_reload", i), reload, vec[i].reload);
        end

        // Twelve cycles of player 1 must hold three impulses spaced one second apart.
        drive(st(0, 0, 1, 0, 0, 0, 0));
        drive(st(0, 1, 0, 0, 0, 0, 0));
        imp_cnt = 0; first_imp = -1; last_imp = -1;
        for (int k = 0; k < 12; k++) begin
            drive(idle_s);
            if (impulse) begin
                imp_cnt++;
                if (first_imp < 0) first_imp = k;
                last_imp = k;
            end
        end
        check("impulses_in_12_cycles", 8'(imp_cnt), 8'd3);
        check("impulse_spacing", 8'(last_imp - first_imp), 8'(2 * TICK_DIV));

        // Move delay: player 2's enable waits DLY impulses after the switch.
        drive(st(0, 0, 0, 1, 0, 0, 0));
        seen = 0; dly_imps = 0;
        for (int k = 0; k < 40; k++) begin
            if (ce_p2) begin
                seen = 1;
                break;
            end
            if (impulse) dly_imps++;
            drive(idle_s);
        end
        check("delay_ce_p2_rises", 8'(seen), 8'd1);
        check("delay_impulse_count", 8'(dly_imps), 8'(DLY));

        for (int k = 0; k < 2000; k++) begin
            rs.clr   = ($urandom_range(0, 299) == 0);
            rs.newg  = ($urandom_range(0, 59) == 0);
            rs.start = ($urandom_range(0, 11) == 0);
            rs.p1    = ($urandom_range(0, 5) == 0);
            rs.p2    = ($urandom_range(0, 5) == 0);
            rs.ovf1  = ($urandom_range(0, 39) == 0);
            rs.ovf2  = ($urandom_range(0, 39) == 0);
            drive(rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
